// File: rtl/mlt_link_ctrl.sv
// Receive-side link controller: hunts for a sync word in the decoded MLT bit
// stream, then deserialises a fixed-length frame MSB-first into bytes.
module mlt_link_ctrl #(
  parameter logic [7:0] SYNC_WORD   = 8'hD5,
  parameter int         FRAME_BYTES = 4,
  parameter int         ERR_LIMIT   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       sym_valid,
  input  logic       rx_bit,
  input  logic       sym_err,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_done,
  output logic       locked,
  output logic       lost_lock,
  output logic [1:0] state,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HUNT = 2'd1,
    RECV = 2'd2
  } state_t;

  localparam int BW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam int RW = (ERR_LIMIT > 1) ? $clog2(ERR_LIMIT) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(FRAME_BYTES - 1);
  localparam logic [RW-1:0] LAST_ERR  = RW'(ERR_LIMIT - 1);

  state_t        state_q;
  logic [6:0]    shreg;     // only the 7 newest hunt bits need keeping
  logic [3:0]    hunt_cnt;  // saturates at 8
  logic [6:0]    byte_sr;
  logic [2:0]    bit_cnt;
  logic [BW-1:0] byte_cnt;
  logic [RW-1:0] err_run;

  logic       accept;
  logic       errored;
  logic [7:0] hunt_shift;
  logic [7:0] byte_shift;
  logic       sync_hit;

  assign accept     = sym_valid & ~sym_err;
  assign errored    = sym_valid & sym_err;
  assign hunt_shift = {shreg, rx_bit};
  assign byte_shift = {byte_sr, rx_bit};
  assign sync_hit   = (hunt_cnt >= 4'd7) && (hunt_shift == SYNC_WORD);

  assign state  = state_q;
  assign locked = (state_q == RECV);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shreg      <= '0;
      hunt_cnt   <= '0;
      byte_sr    <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      err_run    <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      frame_done <= 1'b0;
      lost_lock  <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every branch reads pre-edge state;
      // pulses default low here and are raised for one cycle below.
      byte_valid <= 1'b0;
      frame_done <= 1'b0;
      lost_lock  <= 1'b0;

      if (!en) begin
        state_q  <= IDLE;
        shreg    <= '0;
        hunt_cnt <= '0;
        bit_cnt  <= '0;
        byte_cnt <= '0;
        err_run  <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            state_q  <= HUNT;
            shreg    <= '0;
            hunt_cnt <= '0;
          end

          HUNT: begin
            if (errored) begin
              shreg    <= '0;
              hunt_cnt <= '0;
            end else if (accept) begin
              shreg    <= hunt_shift[6:0];
              hunt_cnt <= (hunt_cnt == 4'd8) ? 4'd8 : hunt_cnt + 4'd1;
              if (sync_hit) begin
                state_q  <= RECV;
                bit_cnt  <= '0;
                byte_cnt <= '0;
                err_run  <= '0;
              end
            end
          end

          RECV: begin
            if (errored) begin
              if (err_run == LAST_ERR) begin
                state_q   <= HUNT;
                lost_lock <= 1'b1;
                shreg     <= '0;
                hunt_cnt  <= '0;
                bit_cnt   <= '0;
                err_run   <= '0;
              end else begin
                err_run <= err_run + RW'(1);
              end
            end else if (accept) begin
              err_run <= '0;
              byte_sr <= byte_shift[6:0];
              if (bit_cnt == 3'd7) begin
                bit_cnt    <= '0;
                byte_data  <= byte_shift;
                byte_valid <= 1'b1;
                if (byte_cnt == LAST_BYTE) begin
                  frame_done <= 1'b1;
                  state_q    <= HUNT;
                  shreg      <= '0;
                  hunt_cnt   <= '0;
                  byte_cnt   <= '0;
                end else begin
                  byte_cnt <= byte_cnt + BW'(1);
                end
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end

          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Error tally follows the state, not en: a strobe seen while hunting or
  // receiving is counted even if en drops on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (errored && (state_q == HUNT || state_q == RECV) &&
                 (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule
